// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// a variable-latency instruction memory.
//   imem_req    : fetch request valid (fetch -> mem)
//   imem_addr   : fetch address (fetch -> mem)
//   imem_ready  : memory accepts the request this cycle (mem -> fetch)
//   imem_rvalid : response valid, one per accepted request (mem -> fetch)
//   imem_rdata  : instruction word, valid with imem_rvalid (mem -> fetch)
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC and keeps at most one request outstanding to instruction memory.
// Responses that arrive under stall are parked in a hold buffer; a redirect
// flushes IF/ID and squashes any in-flight or buffered fetch.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : load-use stall, holds IF/ID
//   redirect_valid  : taken branch/jump from EX
//   redirect_pc     : redirect target (4-byte aligned)
//   imem            : instruction-memory bundle (master side)
//   if_id_valid     : IF/ID holds a real instruction
//   if_id_pc        : PC of the IF/ID instruction
//   if_id_instr     : IF/ID instruction, NOP_INSTR for bubbles
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_pc,
   fetch_stage_if.master imem,
   output logic          if_id_valid,
   output logic [31:0]   if_id_pc,
   output logic [31:0]   if_id_instr
);

   typedef enum logic [1:0] {StReq, StWait, StHold, StKill} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] hold_instr_q;
   logic [31:0] hold_pc_q;
   logic        if_id_valid_q;
   logic [31:0] if_id_pc_q;
   logic [31:0] if_id_instr_q;

   logic        accept;
   logic [31:0] pc_plus4;

   assign imem.imem_req  = (state_q == StReq) && !rst;
   assign imem.imem_addr = pc_q;
   assign accept         = imem.imem_req && imem.imem_ready;
   assign pc_plus4       = pc_q + 32'd4;   // wraps modulo 2^32

   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Any outstanding response is abandoned; memory resets alongside.
         state_q       <= StReq;
         pc_q          <= RESET_PC;
         hold_instr_q  <= '0;
         hold_pc_q     <= '0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
      end else if (redirect_valid) begin
         // Redirect beats stall: flush IF/ID and restart at the target.
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
         pc_q          <= redirect_pc;
         unique case (state_q)
            // A request accepted now will still answer; swallow it in KILL.
            StReq:   state_q <= accept ? StKill : StReq;
            StWait:  state_q <= imem.imem_rvalid ? StReq : StKill;
            StHold:  state_q <= StReq;
            StKill:  state_q <= imem.imem_rvalid ? StReq : StKill;
            default: state_q <= StReq;
         endcase
      end else begin
         // Default when not stalled: bubble unless a delivery below overrides.
         if (!stall) begin
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
         end
         unique case (state_q)
            StReq: begin
               if (accept) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (imem.imem_rvalid) begin
                  pc_q <= pc_plus4;
                  if (!stall) begin
                     if_id_valid_q <= 1'b1;
                     if_id_pc_q    <= pc_q;
                     if_id_instr_q <= imem.imem_rdata;
                     state_q       <= StReq;
                  end else begin
                     hold_instr_q <= imem.imem_rdata;
                     hold_pc_q    <= pc_q;
                     state_q      <= StHold;
                  end
               end
            end
            StHold: begin
               if (!stall) begin
                  if_id_valid_q <= 1'b1;
                  if_id_pc_q    <= hold_pc_q;
                  if_id_instr_q <= hold_instr_q;
                  state_q       <= StReq;
               end
            end
            StKill: begin
               if (imem.imem_rvalid) begin
                  state_q <= StReq;
               end
            end
            default: state_q <= StReq;
         endcase
      end
   end

endmodule
